// File: rtl/uart_rx_fifo.sv
// Oversampled 8-bit UART receiver feeding a first-word-fall-through receive FIFO.
// Define UART_RX_PARITY_EN for 8E1 framing with a sticky parity flag; default is 8N1.
module uart_rx_fifo #(
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter int unsigned FIFO_DEPTH   = 16
) (
  input  logic                        clk_i,
  input  logic                        rst,
  input  logic                        uart_rx,
  input  logic                        rd_en_i,
  input  logic                        clr_err_i,
  output logic [7:0]                  rd_data_o,
  output logic                        empty_o,
  output logic                        full_o,
  output logic [$clog2(FIFO_DEPTH):0] count_o,
  output logic                        frame_err_o,
  output logic                        overrun_o,
  output logic                        parity_err_o
);

  localparam int unsigned AddrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CntW  = $clog2(CLKS_PER_BIT);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop} state_e;
`else
  typedef enum logic [2:0] {StIdle, StStart, StData, StStop} state_e;
`endif

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        shift_q, shift_d;
  logic              stop_sample;
  logic              rx_meta_q, rx_s, rx_prev_q;
  logic              falling;

  logic [7:0]        mem [FIFO_DEPTH];
  logic [AddrW:0]    wr_ptr_q, rd_ptr_q;
  logic              push, pop;
  logic              frame_set, overrun_set;
  logic              frame_err_q, overrun_q;

  // Synchroniser plus one extra stage for edge detection; all idle high.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      rx_meta_q <= 1'b1;
      rx_s      <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= uart_rx;
      rx_s      <= rx_meta_q;
      rx_prev_q <= rx_s;
    end
  end

  // A line held low after a bad stop bit never shows a 1->0 transition, so breaks
  // yield one framing error only.
  assign falling = rx_prev_q & ~rx_s;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

`ifdef UART_RX_PARITY_EN
  logic par_set;
  logic parity_err_q;
`endif

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    bit_d       = bit_q;
    shift_d     = shift_q;
    stop_sample = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_set     = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (falling) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          if (rx_s) begin
            state_d = StIdle;
            cnt_d   = '0;
          end else begin
            state_d = StData;
            // First data interval is one cycle short of a full bit.
            cnt_d   = CntW'(1);
            bit_d   = '0;
          end
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[7:1]};
          bit_d   = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_RX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      StParity: begin
        if (cnt_q == BitLast) begin
          cnt_d   = '0;
          par_set = rx_s ^ (^shift_q);
          state_d = StStop;
        end
      end
`endif
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d       = '0;
          stop_sample = 1'b1;
          state_d     = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
  end

  assign pop         = rd_en_i & ~empty_o;
  assign push        = stop_sample & rx_s & (~full_o | pop);
  assign overrun_set = stop_sample & rx_s & full_o & ~pop;
  assign frame_set   = stop_sample & ~rx_s;

  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr_q[AddrW-1:0]] <= shift_q;
  end

  assign empty_o   = (wr_ptr_q == rd_ptr_q);
  assign full_o    = (wr_ptr_q[AddrW-1:0] == rd_ptr_q[AddrW-1:0]) &&
                     (wr_ptr_q[AddrW] != rd_ptr_q[AddrW]);
  assign count_o   = wr_ptr_q - rd_ptr_q;
  assign rd_data_o = empty_o ? 8'h00 : mem[rd_ptr_q[AddrW-1:0]];

  // Set events take priority over a simultaneous clear.
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= frame_set | (frame_err_q & ~clr_err_i);
      overrun_q   <= overrun_set | (overrun_q & ~clr_err_i);
    end
  end

  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;

`ifdef UART_RX_PARITY_EN
  always_ff @(posedge clk_i or posedge rst) begin
    if (rst) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= par_set | (parity_err_q & ~clr_err_i);
    end
  end
  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

endmodule
